// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB target: FSM states, default device
// address and the register-file reset image.
package sccb_pkg;

    localparam logic [7:0] DEV_ADDR_DEF = 8'h60;

    localparam logic [7:0] REG_PID  = 8'h0A;
    localparam logic [7:0] REG_VER  = 8'h0B;
    localparam logic [7:0] REG_COM7 = 8'h12;
    localparam logic [7:0] REG_TSLB = 8'h3A;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_A_ACK,
        ST_SUB,
        ST_S_ACK,
        ST_WDATA,
        ST_D_ACK,
        ST_RDATA,
        ST_R_NA,
        ST_WAIT_STOP
    } state_t;

    function automatic logic [7:0] reg_default(input logic [7:0] addr);
        case (addr)
            REG_PID:  return 8'h76;
            REG_VER:  return 8'h73;
            REG_COM7: return 8'h00;
            REG_TSLB: return 8'h0C;
            default:  return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/sccb_if.sv
// Two-wire SCCB pad bundle as seen by the target; sda_oe pulls the pad low.
interface sccb_if;
    logic scl_in;
    logic sda_in;
    logic sda_oe;

    modport master (output scl_in, output sda_in, input  sda_oe);
    modport slave  (input  scl_in, input  sda_in, output sda_oe);
endinterface

// File: rtl/sccb_regfile.sv
// 256x8 camera register file: one write port, bus and side combinational reads.
module sccb_regfile
    import sccb_pkg::*;
(
    input  logic       clk_25,
    input  logic       rst,
    input  logic       we_i,
    input  logic [7:0] waddr_i,
    input  logic [7:0] wdata_i,
    input  logic [7:0] raddr_i,
    output logic [7:0] rdata_o,
    input  logic [7:0] cfg_addr_i,
    output logic [7:0] cfg_data_o
);

    logic [7:0] mem_q [256];

    always_ff @(posedge clk_25 or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) begin
                mem_q[i] <= reg_default(8'(i));
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o    = mem_q[raddr_i];
    assign cfg_data_o = mem_q[cfg_addr_i];

endmodule

// File: rtl/sccb_target.sv
// Oversampled SCCB target: pad synchronizers, START/STOP/edge detect, protocol
// FSM and byte shifter in front of the register file.
//  state     | meaning
//  IDLE      | bus free, waiting for START
//  ADDR      | shifting in the device address
//  A_ACK     | driving the address ACK
//  SUB       | shifting the sub-address into ptr
//  S_ACK     | driving the sub-address ACK
//  WDATA     | shifting in a write data byte
//  D_ACK     | driving the data ACK
//  RDATA     | driving read data bits
//  R_NA      | bus released, sampling master ACK/NA
//  WAIT_STOP | not addressed or read done; wait for STOP/START
module sccb_target
    import sccb_pkg::*;
#(
    parameter logic [7:0] DEV_ADDR    = DEV_ADDR_DEF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_25,
    input  logic       rst,
    sccb_if.slave      bus,
    output logic       busy,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       addr_err,
    input  logic [7:0] cfg_addr,
    output logic [7:0] cfg_data
);

    localparam logic [7:0] RD_ADDR = DEV_ADDR | 8'h01;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_dly_q, sda_dly_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_ev, stop_ev;

    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] ptr_q, ptr_d;
    logic       rd_dir_q, rd_dir_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic       wr_strobe_q, wr_strobe_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       addr_err_q, addr_err_d;
    logic [7:0] byte_in, rd_addr, rd_data;

    always_ff @(posedge clk_25 or negedge rst) begin
        if (!rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_dly_q  <= 1'b1;
            sda_dly_q  <= 1'b1;
        end else begin
            scl_sync_q[0] <= bus.scl_in;
            sda_sync_q[0] <= bus.sda_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                scl_sync_q[i] <= scl_sync_q[i-1];
                sda_sync_q[i] <= sda_sync_q[i-1];
            end
            scl_dly_q <= scl_s;
            sda_dly_q <= sda_s;
        end
    end

    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_dly_q;
    assign scl_fall = ~scl_s & scl_dly_q;
    assign start_ev = scl_s & scl_dly_q & ~sda_s & sda_dly_q;
    assign stop_ev  = scl_s & scl_dly_q & sda_s & ~sda_dly_q;

    assign byte_in = {shift_q[6:0], sda_s};
    // R_NA preloads the following byte, so it looks one address ahead
    assign rd_addr = (state_q == ST_R_NA) ? ptr_q + 8'd1 : ptr_q;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        rd_dir_d    = rd_dir_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        addr_err_d  = 1'b0;
        if (start_ev) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b1;
        end else if (stop_ev) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            if (scl_rise && state_q != ST_IDLE && state_q != ST_WAIT_STOP)
                bit_cnt_d = bit_cnt_q + 4'd1;
            case (state_q)
                ST_ADDR: if (scl_rise) begin
                    shift_d = byte_in;
                    if (bit_cnt_q == 4'd7) begin
                        if (byte_in == DEV_ADDR) begin
                            rd_dir_d = 1'b0;
                            state_d  = ST_A_ACK;
                        end else if (byte_in == RD_ADDR) begin
                            rd_dir_d = 1'b1;
                            state_d  = ST_A_ACK;
                        end else begin
                            addr_err_d = 1'b1;
                            state_d    = ST_WAIT_STOP;
                        end
                    end
                end
                ST_SUB: if (scl_rise) begin
                    shift_d = byte_in;
                    if (bit_cnt_q == 4'd7) begin
                        ptr_d   = byte_in;
                        state_d = ST_S_ACK;
                    end
                end
                ST_WDATA: if (scl_rise) begin
                    shift_d = byte_in;
                    if (bit_cnt_q == 4'd7) begin
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = ptr_q;
                        wr_data_d   = byte_in;
                        ptr_d       = ptr_q + 8'd1;
                        state_d     = ST_D_ACK;
                    end
                end
                // count 8 = fall after the byte, count 9 = fall after the ACK bit
                ST_A_ACK, ST_S_ACK, ST_D_ACK: if (scl_fall) begin
                    if (bit_cnt_q == 4'd8) begin
                        sda_oe_d = 1'b1;
                    end else if (bit_cnt_q == 4'd9) begin
                        bit_cnt_d = '0;
                        sda_oe_d  = 1'b0;
                        if (state_q == ST_A_ACK && rd_dir_q) begin
                            shift_d  = rd_data;
                            sda_oe_d = ~rd_data[7];
                            state_d  = ST_RDATA;
                        end else if (state_q == ST_A_ACK) begin
                            state_d = ST_SUB;
                        end else begin
                            state_d = ST_WDATA;
                        end
                    end
                end
                ST_RDATA: if (scl_fall) begin
                    if (bit_cnt_q == 4'd0) begin
                        sda_oe_d = ~shift_q[7];
                    end else if (bit_cnt_q < 4'd8) begin
                        shift_d  = {shift_q[6:0], 1'b1};
                        sda_oe_d = ~shift_q[6];
                    end else begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_R_NA;
                    end
                end
                ST_R_NA: if (scl_rise) begin
                    ptr_d = ptr_q + 8'd1;
                    if (sda_s) begin
                        state_d = ST_WAIT_STOP;
                    end else begin
                        shift_d   = rd_data;
                        bit_cnt_d = '0;
                        state_d   = ST_RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_25 or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            rd_dir_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            rd_dir_q    <= rd_dir_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            addr_err_q  <= addr_err_d;
        end
    end

    sccb_regfile u_regfile (
        .clk_25     (clk_25),
        .rst        (rst),
        .we_i       (wr_strobe_d),
        .waddr_i    (ptr_q),
        .wdata_i    (byte_in),
        .raddr_i    (rd_addr),
        .rdata_o    (rd_data),
        .cfg_addr_i (cfg_addr),
        .cfg_data_o (cfg_data)
    );

    assign bus.sda_oe = sda_oe_q;
    assign busy       = busy_q;
    assign wr_strobe  = wr_strobe_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_sccb_target.sv
// Bench for sccb_target: a bit-banged SCCB master on a wired-AND sda line, with
// a transaction-level register/pointer model and a write-strobe scoreboard.
module tb_sccb_target;

    logic clk_25 = 1'b0;
    logic rst    = 1'b0;
    always #20 clk_25 = ~clk_25;

    sccb_if bus();
    logic sda_m = 1'b1;
    assign bus.sda_in = sda_m & ~bus.sda_oe;

    logic       busy, wr_strobe, addr_err;
    logic [7:0] wr_addr, wr_data, cfg_data;
    logic [7:0] cfg_addr = 8'h00;

    sccb_target dut (
        .clk_25    (clk_25),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .addr_err  (addr_err),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data)
    );

    int checks   = 0;
    int failures = 0;
    int half     = 16;

    logic [7:0]  mregs [256];
    logic [7:0]  mptr;
    logic [15:0] exp_q[$];
    logic [15:0] strobe_q[$];
    int          aerr_cnt = 0;
    logic        oe_seen  = 1'b0;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] exp;
    } cfg_vec_t;
    cfg_vec_t rst_tab [6];

    always @(negedge clk_25) begin
        if (wr_strobe) strobe_q.push_back({wr_addr, wr_data});
        if (addr_err) aerr_cnt++;
        if (bus.sda_oe) oe_seen = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk_25);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) mregs[i] = 8'h00;
        mregs[8'h0A] = 8'h76;
        mregs[8'h0B] = 8'h73;
        mregs[8'h12] = 8'h00;
        mregs[8'h3A] = 8'h0C;
        mptr = 8'h00;
        exp_q.delete();
        strobe_q.delete();
    endtask

    task automatic cfg_chk(input string name, input logic [7:0] a, input logic [7:0] e);
        cfg_addr = a;
        clks(1);
        check(name, 32'(cfg_data), 32'(e));
    endtask

    task automatic do_start();
        sda_m = 1'b1; clks(half);
        bus.scl_in = 1'b1; clks(half);
        sda_m = 1'b0; clks(half);
        bus.scl_in = 1'b0; clks(half);
    endtask

    task automatic do_stop();
        sda_m = 1'b0; clks(half);
        bus.scl_in = 1'b1; clks(half);
        sda_m = 1'b1; clks(half);
    endtask

    task automatic put_bit(input logic b);
        clks(half / 2); sda_m = b; clks(half - half / 2);
        bus.scl_in = 1'b1; clks(half);
        bus.scl_in = 1'b0;
    endtask

    task automatic get_bit(output logic b, input logic drive);
        clks(half / 2); sda_m = drive; clks(half - half / 2);
        bus.scl_in = 1'b1; clks(half / 2);
        b = bus.sda_in;
        clks(half - half / 2);
        bus.scl_in = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(b[i]);
        get_bit(ack, 1'b1);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d, output logic oe9);
        logic bv;
        for (int i = 7; i >= 0; i--) begin
            get_bit(bv, 1'b1);
            d[i] = bv;
        end
        clks(half / 2); sda_m = nack; clks(half - half / 2);
        bus.scl_in = 1'b1; clks(half / 2);
        oe9 = bus.sda_oe;
        clks(half - half / 2);
        bus.scl_in = 1'b0;
    endtask

    task automatic write_body(input logic [7:0] sub, input int n, input logic [23:0] data);
        logic       ack;
        logic [7:0] b;
        send_byte(8'h60, ack);
        check("wr_dev_ack", 32'(ack), 32'(0));
        check("busy_in_txn", 32'(busy), 32'(1));
        send_byte(sub, ack);
        check("wr_sub_ack", 32'(ack), 32'(0));
        mptr = sub;
        for (int k = 0; k < n; k++) begin
            b = data[8*k +: 8];
            send_byte(b, ack);
            check("wr_data_ack", 32'(ack), 32'(0));
            exp_q.push_back({mptr, b});
            mregs[mptr] = b;
            mptr = mptr + 8'd1;
        end
    endtask

    task automatic write_txn(input logic [7:0] sub, input int n, input logic [23:0] data);
        do_start();
        write_body(sub, n, data);
        do_stop();
        check("busy_after_stop", 32'(busy), 32'(0));
    endtask

    task automatic read_txn(input int n);
        logic       ack, oe9;
        logic [7:0] d;
        do_start();
        send_byte(8'h61, ack);
        check("rd_dev_ack", 32'(ack), 32'(0));
        for (int k = 0; k < n; k++) begin
            recv_byte(k == n - 1, d, oe9);
            check("rd_data", 32'(d), 32'(mregs[mptr]));
            mptr = mptr + 8'd1;
            if (k == n - 1) check("rd_bit9_released", 32'(oe9), 32'(0));
        end
        do_stop();
        check("busy_after_stop", 32'(busy), 32'(0));
    endtask

    task automatic bad_txn(input logic [7:0] a);
        logic ack;
        int   aerr0;
        aerr0   = aerr_cnt;
        oe_seen = 1'b0;
        do_start();
        send_byte(a, ack);
        check("bad_addr_noack", 32'(ack), 32'(1));
        send_byte(8'h12, ack);
        check("bad_data_noack", 32'(ack), 32'(1));
        do_stop();
        check("addr_err_pulses", 32'(aerr_cnt - aerr0), 32'(1));
        check("bad_never_drives", 32'(oe_seen), 32'(0));
    endtask

    task automatic check_strobes();
        logic [15:0] a, e;
        clks(4);
        check("strobe_count", 32'(strobe_q.size()), 32'(exp_q.size()));
        while (strobe_q.size() > 0 && exp_q.size() > 0) begin
            a = strobe_q.pop_front();
            e = exp_q.pop_front();
            check("strobe_addr_data", 32'(a), 32'(e));
        end
        strobe_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic       ack;
        logic [7:0] a;
        int         kind;

        rst_tab[0] = '{8'h0A, 8'h76};
        rst_tab[1] = '{8'h0B, 8'h73};
        rst_tab[2] = '{8'h12, 8'h00};
        rst_tab[3] = '{8'h3A, 8'h0C};
        rst_tab[4] = '{8'h00, 8'h00};
        rst_tab[5] = '{8'hFF, 8'h00};

        bus.scl_in = 1'b1;
        sda_m      = 1'b1;
        model_reset();
        clks(4);
        rst = 1'b1;
        clks(4);

        check("rst_sda_oe", 32'(bus.sda_oe), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_wr_strobe", 32'(wr_strobe), 32'(0));
        check("rst_addr_err", 32'(addr_err), 32'(0));
        check("rst_wr_addr", 32'(wr_addr), 32'(0));
        check("rst_wr_data", 32'(wr_data), 32'(0));
        for (int i = 0; i < 6; i++) cfg_chk("rst_default", rst_tab[i].addr, rst_tab[i].exp);

        // 3-phase write at scl period 256
        half = 128;
        write_txn(8'h12, 1, 24'h000080);
        check_strobes();
        cfg_chk("cfg_after_write", 8'h12, 8'h80);
        check("last_wr_addr", 32'(wr_addr), 32'(8'h12));
        check("last_wr_data", 32'(wr_data), 32'(8'h80));
        half = 16;

        // sub-address write then read of TSLB with NA
        write_txn(8'h3A, 0, 24'h0);
        read_txn(1);
        check("read_id_model", 32'(mregs[8'h3A]), 32'(8'h0C));
        check_strobes();

        bad_txn(8'h42);
        check_strobes();

        // burst across the pointer wrap
        write_txn(8'hFF, 2, 24'h002211);
        check_strobes();
        cfg_chk("wrap_ff", 8'hFF, 8'h11);
        cfg_chk("wrap_00", 8'h00, 8'h22);

        // START after 4 data bits must not commit the partial byte
        do_start();
        write_body(8'h0A, 0, 24'h0);
        for (int i = 7; i >= 4; i--) put_bit(i[0]);
        clks(4);
        check("abort_no_strobe", 32'(strobe_q.size()), 32'(0));
        write_txn(8'h0A, 1, 24'h000055);
        check_strobes();
        cfg_chk("abort_then_write", 8'h0A, 8'h55);

        for (int t = 0; t < 25; t++) begin
            kind = int'($urandom_range(0, 9));
            if (kind <= 4) begin
                write_txn(8'($urandom), int'($urandom_range(0, 3)), 24'($urandom));
            end else if (kind <= 8) begin
                read_txn(int'($urandom_range(1, 3)));
            end else begin
                a = 8'($urandom);
                if (a[7:1] == 7'h30) a = a ^ 8'h80;
                bad_txn(a);
            end
            check_strobes();
            a = 8'($urandom);
            cfg_chk("rand_cfg", a, mregs[a]);
        end

        // reset while the target is driving a 0 data bit
        write_txn(8'h0A, 1, 24'h000055);
        write_txn(8'h0A, 0, 24'h0);
        check_strobes();
        do_start();
        send_byte(8'h61, ack);
        check("rst_rd_ack", 32'(ack), 32'(0));
        clks(half / 2);
        check("rd_driving_low", 32'(bus.sda_oe), 32'(1));
        rst = 1'b0;
        #1;
        check("rst_releases_bus", 32'(bus.sda_oe), 32'(0));
        check("rst_clears_busy", 32'(busy), 32'(0));
        bus.scl_in = 1'b1;
        sda_m      = 1'b1;
        clks(3);
        rst = 1'b1;
        model_reset();
        clks(2);
        for (int i = 0; i < 6; i++) cfg_chk("post_rst_default", rst_tab[i].addr, rst_tab[i].exp);
        read_txn(1);
        check_strobes();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sccb_target.md
# sccb_target

Oversampled SCCB target (camera-side responder) with a 256×8 register file. It answers the camera-configuration master on the same two-wire bus: 3-phase writes, 2-phase sub-address writes and 2-phase reads. Register contents are exported to downstream logic through a side read port. It serves as the synthesizable camera stand-in for board bring-up and as the bus model in system benches.

## Interface
- `DEV_ADDR`, default 8'h60: write device address; the read address is `DEV_ADDR|1` (8'h61).
- `SYNC_STAGES`, default 2: synchronizer depth on `scl_in` and `sda_in`.
- `clk_25`  in  1  system clock, nominally 25 MHz. This is the block's only clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `scl_in`  in  1  bus clock as seen at the pad.
- `sda_in`  in  1  bus data as seen at the pad (pulled up).
- `sda_oe`  out  1  drives the pad low when 1. The pad is released (Z) when 0. This is an open-drain drive.
- `busy`  out  1  high from a START until the next STOP.
- `wr_strobe`  out  1  1-cycle pulse on each register write.
- `wr_addr`  out  8  register address of the last write.
- `wr_data`  out  8  data of the last write.
- `addr_err`  out  1  1-cycle pulse when the device address does not match.
- `cfg_addr`  in  8  side read-port address.
- `cfg_data`  out  8  `regs[cfg_addr]`, combinational.

## Operation
- Both bus inputs pass through `SYNC_STAGES` flops, then one delay flop for edge detection.
- Bus events:
  - START: sda falls while scl is high.
  - STOP: sda rises while scl is high.
  - Bits are sampled on the scl rise.
  - `sda_oe` changes only on the cycle an scl fall is detected.
- Bit counter: 4 bits, cleared on START and after every 9th bit.
- States:
  - IDLE: wait for START → ADDR.
  - ADDR: shift in 8 bits, MSB first.
    - Byte equals `DEV_ADDR` → A_ACK (write).
    - Byte equals `DEV_ADDR|1` → A_ACK (read).
    - Any other byte → pulse `addr_err`, go to WAIT_STOP, never drive.
  - A_ACK: drive 0 during bit 9.
    - Write direction → SUB.
    - Read direction → RDATA, loading the shift register with `regs[ptr]`.
  - SUB: shift in 8 bits into `ptr` → S_ACK (drive 0) → WDATA.
  - WDATA: shift in 8 bits → write `regs[ptr]`, pulse `wr_strobe`, `ptr <= ptr+1` (wraps 8'hFF→8'h00) → D_ACK (drive 0) → WDATA.
  - RDATA: drive each bit; `sda_oe = ~bit` → R_NA. In R_NA the bus is released and bit 9 is sampled:
    - Sampled 1 (NA): `ptr <= ptr+1` → WAIT_STOP.
    - Sampled 0: `ptr <= ptr+1`, load the next byte → RDATA.
  - WAIT_STOP: release the bus; wait for STOP or START.
- A START in any state → ADDR (repeated start), with `sda_oe` forced to 0.
- A STOP in any state → IDLE, with `sda_oe` forced to 0.
- A write interrupted mid-byte by START or STOP does not commit.
- `ptr` persists across transactions. A 2-phase write followed by a 2-phase read therefore returns `regs[sub]`.
- Register-file reset defaults:
  - 8'h0A=8'h76, 8'h0B=8'h73, 8'h12=8'h00, 8'h3A=8'h0C.
  - All other registers reset to 8'h00.

## Timing
- Reset values:
  - `sda_oe=0`, `busy=0`, `wr_strobe=0`, `addr_err=0`, `wr_addr=0`, `wr_data=0`, `ptr=0`.
  - State = IDLE.
  - Synchronizer flops reset to 1.
- Event latency: an edge detect fires `SYNC_STAGES+1` clk_25 cycles after the pad transition.
- `wr_strobe`, `wr_addr` and `wr_data` update together, on the cycle the 8th data-bit scl rise is detected.
- `regs` are written on that same cycle and are visible on `cfg_data` the next cycle.
- ACK low is held from the detected fall after bit 8 to the detected fall after bit 9.
- Minimum scl half-period: 8 clk_25 cycles. The configuration master runs at 128, so there is ample margin.
- STOP and START take priority over a coincident bit sample.
- `rst` asserted mid-byte: all outputs return to reset values immediately, registers return to their defaults, and the bus is released.

## Structure
- Package `sccb_pkg` holds:
  - The state enum.
  - The `DEV_ADDR` default.
  - Register address and default constants: PID 8'h0A, VER 8'h0B, COM7 8'h12, TSLB 8'h3A.
- Sub-module `sccb_regfile`:
  - 256×8 storage, one write port, two combinational read ports (bus and cfg).
  - Async active-low reset to the package defaults.
- Top level contains the synchronizers, event detection, FSM and shift register.

## Test plan
- 3-phase write: 60/12/80 at scl period 256 → three ACK lows; `wr_strobe` once with `wr_addr=12`, `wr_data=80`; `cfg_addr=12` gives `cfg_data=80`.
- Read ID: write 60/3A, STOP, then 61 and read with NA → data byte 0C on the bus, bit 9 released, `busy` falls after STOP.
- Address mismatch: 42/.. → `addr_err` pulse; `sda_oe` stays 0 for the whole transaction; no `wr_strobe`.
- Burst and wrap: 60/FF/11/22 → `regs[FF]=11`, `regs[00]=22`; two strobes.
- Abort: START mid-WDATA after 4 bits, then 60/0A/55 → the aborted byte is not written; `regs[0A]=55`.
- Reset mid-read while driving 0 → `sda_oe=0` within the reset-assert cycle; `regs[0A]` reads 76 afterwards.
